// File: rtl/pipe_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, stage indices,
// control-bundle layout and the canonical control patterns.
package pipe_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctl_t;

    localparam ctl_t CTL_IDLE     = ctl_t'(7'b00000_00);
    localparam ctl_t CTL_RUN      = ctl_t'(7'b11111_00);
    localparam ctl_t CTL_BRANCH   = ctl_t'(7'b11111_11);
    localparam ctl_t CTL_LOAD_USE = ctl_t'(7'b00111_01);
    // Fetch frozen and a bubble fed into IF/ID while older work retires.
    localparam ctl_t CTL_DRAIN    = ctl_t'(7'b01111_10);

    function automatic logic [NUM_STAGES-1:0] shift_valid(
        input logic [NUM_STAGES-1:0] valid,
        input logic                  fetch
    );
        return {valid[NUM_STAGES-2:0], fetch};
    endfunction

endpackage

// File: rtl/pipe_sequencer_hazard_detect.sv
// Raw hazard conditions, each qualified by the live flag of the stage it
// inspects. Priority between them is resolved by the sequencer.
module pipe_sequencer_hazard_detect
    import pipe_sequencer_pkg::*;
(
    input  logic       valid_id,
    input  logic       valid_ex,
    input  logic       valid_mem,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_write_reg,
    input  logic       ex_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       mem_stall,
    output logic       branch,
    output logic       load_use
);

    logic rs_dep;
    logic rt_dep;

    assign rs_dep    = id_use_rs && (id_rs == ex_write_reg);
    assign rt_dep    = id_use_rt && (id_rt == ex_write_reg);

    assign mem_stall = valid_mem && mem_req && !mem_ready;
    assign branch    = valid_ex && ex_branch_taken;
    // $0 is never a real destination, so a load to it creates no dependency.
    assign load_use  = valid_ex && valid_id && ex_mem_to_reg &&
                       (ex_write_reg != REG_ZERO) && (rs_dep || rt_dep);

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencing controller: owns stage live flags, every stage-register
// enable/flush, the halt-drain FSM and a saturating stall-cycle counter.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_halt,
    input  logic                   ex_mem_to_reg,
    input  logic [4:0]             ex_write_reg,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic [NUM_STAGES-1:0]  stage_valid,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    seq_state_e             state_q, state_d;
    logic [NUM_STAGES-1:0]  valid_q, valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    ctl_t                   ctl;
    logic                   stall_event;
    logic                   mem_stall, branch, load_use;

    pipe_sequencer_hazard_detect u_hazard (
        .valid_id        (valid_q[STG_ID]),
        .valid_ex        (valid_q[STG_EX]),
        .valid_mem       (valid_q[STG_MEM]),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_write_reg    (ex_write_reg),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .mem_stall       (mem_stall),
        .branch          (branch),
        .load_use        (load_use)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        ctl         = CTL_IDLE;
        state_d     = state_q;
        valid_d     = valid_q;
        stall_event = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                valid_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_stall) begin
                    stall_event = 1'b1;
                end else if (branch) begin
                    ctl                 = CTL_BRANCH;
                    valid_d             = shift_valid(valid_q, 1'b1);
                    valid_d[STG_ID]     = 1'b0;
                    valid_d[STG_EX]     = 1'b0;
                end else if (load_use) begin
                    // HALT waiting behind a load-use is picked up once the bubble is in.
                    ctl                 = CTL_LOAD_USE;
                    stall_event         = 1'b1;
                    valid_d             = {valid_q[STG_MEM], valid_q[STG_EX], 1'b0,
                                           valid_q[STG_ID], valid_q[STG_IF]};
                end else if (valid_q[STG_ID] && id_halt) begin
                    ctl                 = CTL_DRAIN;
                    valid_d             = shift_valid(valid_q, 1'b0);
                    valid_d[STG_ID]     = 1'b0;
                    state_d             = ST_DRAIN;
                end else begin
                    ctl                 = CTL_RUN;
                    valid_d             = shift_valid(valid_q, 1'b1);
                end
            end
            ST_DRAIN: begin
                // A taken branch here is older than HALT and must not refetch.
                if (mem_stall) begin
                    stall_event = 1'b1;
                end else begin
                    ctl             = CTL_DRAIN;
                    valid_d         = shift_valid(valid_q, 1'b0);
                    valid_d[STG_ID] = 1'b0;
                    if (valid_d == '0) state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                valid_d = '0;
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_event && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            valid_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign stage_valid = valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign stall_count = stall_cnt_q;

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Pipeline sequencing controller for the five-stage CPU. Tracks which stage holds a live instruction and drives every pipeline-register enable and flush from one place. Resolves load-use hazards, taken branches, data-memory wait states and a halt-drain sequence. Sits beside the decode control unit and consumes its decoded fields plus EX/MEM status; the datapath's PC and stage registers obey its enables.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt as a source
- id_halt  in  1  ID instruction is HALT
- ex_mem_to_reg  in  1  EX instruction is a load
- ex_write_reg  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  EX branch resolved taken; PC mux selects target
- mem_req  in  1  MEM instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register load enables
- ifid_flush, idex_flush  out  1 each  load a bubble (NOP, valid=0) into IF/ID, ID/EX
- stage_valid  out  5  live flags, bit0 IF … bit4 WB
- halted  out  1  pipeline drained after HALT
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation
- FSM states: BOOT, RUN, DRAIN, HALTED. Reset → BOOT. BOOT lasts exactly one cycle: all enables 0, stage_valid cleared → RUN.
- Control outputs are combinational from registered state/stage_valid and current inputs. Only state, stage_valid and stall_count are registered.
- Conditions are qualified by the stage's valid bit:
  - mem_stall = valid[3] & mem_req & ~mem_ready
  - branch = valid[2] & ex_branch_taken
  - load_use = valid[2] & valid[1] & ex_mem_to_reg & ex_write_reg≠0 & ((id_use_rs & id_rs==ex_write_reg) | (id_use_rt & id_rt==ex_write_reg))
- Priority is mem_stall > branch > load_use > normal.
  - mem_stall: all enables 0, flushes 0, stage_valid held. A branch or load-use in the same cycle is deferred; it re-evaluates when the stall ends because its inputs are frozen.
  - branch: all enables 1, ifid_flush=idex_flush=1, next valid[1]=valid[2]=0. Branch masks a simultaneous load_use.
  - load_use: pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Next valid[2]=0; valid[1:0] held; valid[4:3] shift.
  - normal (RUN): all enables 1, valid shifts left, new valid[0]=1.
- HALT: when valid[1] & id_halt & no mem_stall & no branch in RUN:
  - pc_en=0 and ifid_flush=1 from that cycle on.
  - HALT proceeds down the pipe; valid[0]=0 thereafter.
  - State → DRAIN.
- DRAIN behaves as RUN with fetch suppressed: pc_en=0, ifid_flush=1. Mem stalls are still honoured. A taken branch in EX in DRAIN is ignored; it is older than the HALT and does not refetch.
- DRAIN → HALTED when stage_valid==0. HALTED: all enables 0, halted=1. Leaving HALTED requires reset.
- stall_count increments on each cycle of mem_stall or load_use in RUN/DRAIN. It saturates at all-ones.

## Timing
- Reset values: state BOOT, stage_valid 0, stall_count 0, all enables 0, flushes 0, halted 0.
- Reset mid-operation: immediate asynchronous return to these values, including during mem_stall or DRAIN.
- Load-use costs exactly 1 bubble cycle. The following cycle re-evaluates with the load in MEM, so there is no hazard.
- Taken branch costs 2 bubbles: the IF and ID contents are squashed in the same cycle that ex_branch_taken is seen.
- mem_stall duration equals the number of cycles with mem_ready low; zero-wait memory adds no cycles.
- HALTED asserts the cycle after the HALT instruction leaves WB, i.e. 4 cycles after HALT is seen in ID when there are no stalls.

## Structure
- Shared package/header (alongside existing definitions): FSM state encodings, stage index constants (IF=0 … WB=4), register 0 constant.
- One sub-module is natural: hazard_detect (combinational load_use/branch/mem_stall computation). The FSM, valid tracking and counter stay in pipe_sequencer.

## Test plan
- Reset release → one BOOT cycle with enables 0, then stage_valid fills 00001→11111 over 5 cycles with all enables 1.
- Load `lw $2` in EX, ID reads rs=2 → one cycle pc_en=ifid_en=0, idex_flush=1, stall_count=1. Same case with ex_write_reg=0 → no stall.
- ex_branch_taken with valid[2]=1 → ifid_flush=idex_flush=1, next stage_valid[2:1]=00. Simultaneous load_use → no stall, stall_count unchanged.
- mem_req with mem_ready low 3 cycles while a branch is in EX → all enables 0 for 3 cycles, stall_count=3. Branch flush occurs on cycle 4.
- id_halt in full pipeline → pc_en=0 thereafter, halted=1 after drain, stall_count frozen. Assert reset mid-DRAIN → all outputs return to reset values asynchronously.
- Force 65 540 load-use cycles → stall_count saturates at 0xFFFF.
